// File: rtl/acc_interconnect_ordered.sv
// acc_interconnect_ordered: hierarchical accelerator interconnect with round-robin local crossbar
// and per-requester route FIFOs that return responses in issue order.
module acc_interconnect_ordered #(
  parameter int DataWidth = 32,
  parameter int NumReq = 2,
  parameter int NumRsp = 3,
  parameter int HierAddrWidth = 2,
  parameter int AccAddrWidth = 4,
  parameter int HierLevel = 0,
  parameter int MaxOutstanding = 4,
  localparam int AW = HierAddrWidth + AccAddrWidth,
  localparam int IdxW = NumReq > 1 ? $clog2(NumReq) : 1,
  localparam int RspIdxW = NumRsp > 1 ? $clog2(NumRsp) : 1,
  localparam int CntW = $clog2(MaxOutstanding + 1),
  localparam int PtrW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           mst_q_valid_i,
  output logic [NumReq-1:0]           mst_q_ready_o,
  input  logic [NumReq*AW-1:0]        mst_q_addr_i,
  input  logic [NumReq*DataWidth-1:0] mst_q_data_i,
  output logic [NumReq-1:0]           mst_p_valid_o,
  input  logic [NumReq-1:0]           mst_p_ready_i,
  output logic [NumReq*DataWidth-1:0] mst_p_data_o,
  output logic [NumReq-1:0]           mst_p_err_o,
  output logic [NumReq-1:0]           nxt_q_valid_o,
  input  logic [NumReq-1:0]           nxt_q_ready_i,
  output logic [NumReq*AW-1:0]        nxt_q_addr_o,
  output logic [NumReq*DataWidth-1:0] nxt_q_data_o,
  input  logic [NumReq-1:0]           nxt_p_valid_i,
  output logic [NumReq-1:0]           nxt_p_ready_o,
  input  logic [NumReq*DataWidth-1:0] nxt_p_data_i,
  input  logic [NumReq-1:0]           nxt_p_err_i,
  output logic [NumRsp-1:0]           slv_q_valid_o,
  input  logic [NumRsp-1:0]           slv_q_ready_i,
  output logic [NumRsp*AW-1:0]        slv_q_addr_o,
  output logic [NumRsp*DataWidth-1:0] slv_q_data_o,
  output logic [NumRsp*IdxW-1:0]      slv_q_id_o,
  input  logic [NumRsp-1:0]           slv_p_valid_i,
  output logic [NumRsp-1:0]           slv_p_ready_o,
  input  logic [NumRsp*DataWidth-1:0] slv_p_data_i,
  input  logic [NumRsp-1:0]           slv_p_err_i,
  input  logic [NumRsp*IdxW-1:0]      slv_p_id_i,
  output logic [NumReq*CntW-1:0]      outstanding_o
);
  typedef enum logic [1:0] {LOC, BYP, ERR} route_e;
  typedef struct packed {
    route_e r;
    logic [RspIdxW-1:0] k;
  } route_t;
  route_t dec [NumReq];
  route_t head [NumReq];
  route_t mem [NumReq][MaxOutstanding];
  logic [PtrW-1:0] wp [NumReq];
  logic [PtrW-1:0] rp [NumReq];
  logic [CntW-1:0] cnt [NumReq];
  logic [IdxW-1:0] ptr [NumRsp];
  logic [IdxW-1:0] win [NumRsp];
  logic [NumRsp-1:0] found;
  logic [NumReq-1:0] full, empty, push, pop;
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      dec[i].k = mst_q_addr_i[i*AW +: RspIdxW];
      dec[i].r = mst_q_addr_i[i*AW+AccAddrWidth +: HierAddrWidth] != HierAddrWidth'(HierLevel) ? BYP :
                 int'(dec[i].k) >= NumRsp ? ERR : LOC;
      full[i] = cnt[i] == CntW'(MaxOutstanding);
      empty[i] = cnt[i] == '0;
      head[i] = mem[i][rp[i]];
    end
  end
  // Per-responder round-robin: first eligible requester at or after the pointer wins.
  always_comb begin
    int idx;
    idx = 0;
    found = '0;
    for (int k = 0; k < NumRsp; k++) begin
      win[k] = '0;
      for (int o = 0; o < NumReq; o++) begin
        idx = (int'(ptr[k]) + o) % NumReq;
        if (!found[k] && mst_q_valid_i[idx] && !full[idx] && dec[idx].r == LOC && int'(dec[idx].k) == k) begin
          found[k] = 1'b1;
          win[k] = IdxW'(idx);
        end
      end
    end
  end
  always_comb begin
    slv_q_valid_o = '0;
    slv_q_addr_o = '0;
    slv_q_data_o = '0;
    slv_q_id_o = '0;
    for (int k = 0; k < NumRsp; k++) begin
      slv_q_valid_o[k] = found[k] && !rst_i;
      slv_q_addr_o[k*AW +: AW] = mst_q_addr_i[int'(win[k])*AW +: AW];
      slv_q_data_o[k*DataWidth +: DataWidth] = mst_q_data_i[int'(win[k])*DataWidth +: DataWidth];
      slv_q_id_o[k*IdxW +: IdxW] = win[k];
    end
  end
  always_comb begin
    mst_q_ready_o = '0;
    nxt_q_valid_o = '0;
    push = '0;
    for (int i = 0; i < NumReq; i++) begin
      mst_q_ready_o[i] = !rst_i && !full[i] && (dec[i].r == BYP ? nxt_q_ready_i[i] : dec[i].r == ERR ? 1'b1 :
                         found[dec[i].k] && win[dec[i].k] == IdxW'(i) && slv_q_ready_i[dec[i].k]);
      nxt_q_valid_o[i] = !rst_i && !full[i] && mst_q_valid_i[i] && dec[i].r == BYP;
      push[i] = mst_q_valid_i[i] && mst_q_ready_o[i];
    end
  end
  assign nxt_q_addr_o = mst_q_addr_i;
  assign nxt_q_data_o = mst_q_data_i;
  // Response side: only the head of each route FIFO may complete, which enforces issue order.
  always_comb begin
    int k;
    k = 0;
    mst_p_valid_o = '0;
    mst_p_data_o = '0;
    mst_p_err_o = '0;
    nxt_p_ready_o = '0;
    pop = '0;
    for (int i = 0; i < NumReq; i++) begin
      k = int'(head[i].k);
      mst_p_valid_o[i] = !rst_i && !empty[i] && (head[i].r == BYP ? nxt_p_valid_i[i] : head[i].r == ERR ? 1'b1 :
                         k < NumRsp && slv_p_valid_i[k] && slv_p_id_i[k*IdxW +: IdxW] == IdxW'(i));
      mst_p_data_o[i*DataWidth +: DataWidth] = head[i].r == BYP ? nxt_p_data_i[i*DataWidth +: DataWidth] :
                                               head[i].r == ERR ? '0 : slv_p_data_i[k*DataWidth +: DataWidth];
      mst_p_err_o[i] = head[i].r == BYP ? nxt_p_err_i[i] : head[i].r == ERR ? 1'b1 : slv_p_err_i[k];
      nxt_p_ready_o[i] = !rst_i && !empty[i] && head[i].r == BYP && mst_p_ready_i[i];
      pop[i] = mst_p_valid_o[i] && mst_p_ready_i[i];
    end
  end
  always_comb begin
    int j;
    j = 0;
    slv_p_ready_o = '0;
    for (int k = 0; k < NumRsp; k++) begin
      j = int'(slv_p_id_i[k*IdxW +: IdxW]);
      slv_p_ready_o[k] = !rst_i && j < NumReq && !empty[j] && head[j].r == LOC && int'(head[j].k) == k && mst_p_ready_i[j];
    end
  end
  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < NumReq; i++) outstanding_o[i*CntW +: CntW] = cnt[i];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumReq; i++) begin
        cnt[i] <= '0;
        wp[i] <= '0;
        rp[i] <= '0;
      end
      for (int k = 0; k < NumRsp; k++) ptr[k] <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (push[i]) begin
          mem[i][wp[i]] <= dec[i];
          wp[i] <= wp[i] == PtrW'(MaxOutstanding - 1) ? '0 : wp[i] + 1'b1;
        end
        if (pop[i]) rp[i] <= rp[i] == PtrW'(MaxOutstanding - 1) ? '0 : rp[i] + 1'b1;
        cnt[i] <= cnt[i] + CntW'(push[i]) - CntW'(pop[i]);
      end
      for (int k = 0; k < NumRsp; k++)
        if (slv_q_valid_o[k] && slv_q_ready_i[k]) ptr[k] <= IdxW'((int'(win[k]) + 1) % NumReq);
    end
  end
endmodule

// File: tb/tb_acc_interconnect_ordered.sv
// tb_acc_interconnect_ordered: directed vector table for request routing plus hand-written
// sequences for ordering, outstanding limit, error responses, contention and reset.
module tb_acc_interconnect_ordered;
  logic clk = 1'b0;
  logic rst_i;
  logic [1:0] mst_q_valid_i, mst_q_ready_o, mst_p_valid_o, mst_p_ready_i, mst_p_err_o;
  logic [11:0] mst_q_addr_i, nxt_q_addr_o;
  logic [63:0] mst_q_data_i, mst_p_data_o, nxt_q_data_o, nxt_p_data_i;
  logic [1:0] nxt_q_valid_o, nxt_q_ready_i, nxt_p_valid_i, nxt_p_ready_o, nxt_p_err_i;
  logic [2:0] slv_q_valid_o, slv_q_ready_i, slv_q_id_o, slv_p_valid_i, slv_p_ready_o, slv_p_err_i, slv_p_id_i;
  logic [17:0] slv_q_addr_o;
  logic [95:0] slv_q_data_o, slv_p_data_i;
  logic [5:0] outstanding_o;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [5:0] addr;
    logic [2:0] sr;
    logic nr;
    logic rdy;
    logic nv;
    logic [2:0] sv;
  } vec_t;
  vec_t tv [9];
  acc_interconnect_ordered dut (
    .clk_i(clk), .rst_i(rst_i),
    .mst_q_valid_i(mst_q_valid_i), .mst_q_ready_o(mst_q_ready_o), .mst_q_addr_i(mst_q_addr_i), .mst_q_data_i(mst_q_data_i),
    .mst_p_valid_o(mst_p_valid_o), .mst_p_ready_i(mst_p_ready_i), .mst_p_data_o(mst_p_data_o), .mst_p_err_o(mst_p_err_o),
    .nxt_q_valid_o(nxt_q_valid_o), .nxt_q_ready_i(nxt_q_ready_i), .nxt_q_addr_o(nxt_q_addr_o), .nxt_q_data_o(nxt_q_data_o),
    .nxt_p_valid_i(nxt_p_valid_i), .nxt_p_ready_o(nxt_p_ready_o), .nxt_p_data_i(nxt_p_data_i), .nxt_p_err_i(nxt_p_err_i),
    .slv_q_valid_o(slv_q_valid_o), .slv_q_ready_i(slv_q_ready_i), .slv_q_addr_o(slv_q_addr_o), .slv_q_data_o(slv_q_data_o),
    .slv_q_id_o(slv_q_id_o), .slv_p_valid_i(slv_p_valid_i), .slv_p_ready_o(slv_p_ready_o), .slv_p_data_i(slv_p_data_i),
    .slv_p_err_i(slv_p_err_i), .slv_p_id_i(slv_p_id_i), .outstanding_o(outstanding_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    mst_q_valid_i = '0; mst_q_addr_i = '0; mst_q_data_i = '0; mst_p_ready_i = '0;
    nxt_q_ready_i = '0; nxt_p_valid_i = '0; nxt_p_data_i = '0; nxt_p_err_i = '0;
    slv_q_ready_i = '0; slv_p_valid_i = '0; slv_p_data_i = '0; slv_p_err_i = '0; slv_p_id_i = '0;
  endtask
  initial begin
    tv[0] = '{6'h01, 3'b111, 1'b1, 1'b1, 1'b0, 3'b010};
    tv[1] = '{6'h00, 3'b111, 1'b0, 1'b1, 1'b0, 3'b001};
    tv[2] = '{6'h02, 3'b000, 1'b1, 1'b0, 1'b0, 3'b100};
    tv[3] = '{6'h03, 3'b111, 1'b1, 1'b1, 1'b0, 3'b000};
    tv[4] = '{6'h0F, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000};
    tv[5] = '{6'h04, 3'b001, 1'b0, 1'b1, 1'b0, 3'b001};
    tv[6] = '{6'h11, 3'b111, 1'b0, 1'b0, 1'b1, 3'b000};
    tv[7] = '{6'h31, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000};
    tv[8] = '{6'h0E, 3'b011, 1'b0, 1'b0, 1'b0, 3'b100};
    rst_i = 1'b1;
    mst_q_valid_i = '1; mst_q_addr_i = '0; mst_q_data_i = '1; mst_p_ready_i = '1;
    nxt_q_ready_i = '1; nxt_p_valid_i = '1; nxt_p_data_i = '1; nxt_p_err_i = '1;
    slv_q_ready_i = '1; slv_p_valid_i = '1; slv_p_data_i = '1; slv_p_err_i = '1; slv_p_id_i = '0;
    repeat (3) begin
      tick();
      chk("rst_q_ready", 64'(mst_q_ready_o), 0);
      chk("rst_p_valid", 64'(mst_p_valid_o), 0);
      chk("rst_nxt_q_valid", 64'(nxt_q_valid_o), 0);
      chk("rst_nxt_p_ready", 64'(nxt_p_ready_o), 0);
      chk("rst_slv_q_valid", 64'(slv_q_valid_o), 0);
      chk("rst_slv_p_ready", 64'(slv_p_ready_o), 0);
      chk("rst_outstanding", 64'(outstanding_o), 0);
    end
    idle();
    tick();
    rst_i = 1'b0;
    tick();
    for (int v = 0; v < 9; v++) begin
      mst_q_valid_i = 2'b01;
      mst_q_addr_i[5:0] = tv[v].addr;
      slv_q_ready_i = tv[v].sr;
      nxt_q_ready_i = {1'b0, tv[v].nr};
      #1;
      chk($sformatf("vec%0d_ready", v), 64'(mst_q_ready_o[0]), 64'(tv[v].rdy));
      chk($sformatf("vec%0d_nxt_valid", v), 64'(nxt_q_valid_o[0]), 64'(tv[v].nv));
      chk($sformatf("vec%0d_slv_valid", v), 64'(slv_q_valid_o), 64'(tv[v].sv));
      idle();
      tick();
    end
    chk("table_no_push", 64'(outstanding_o), 0);
    mst_q_valid_i = 2'b01; mst_q_addr_i[5:0] = 6'h01; mst_q_data_i[31:0] = 32'hA5; slv_q_ready_i = 3'b010;
    #1;
    chk("loc_slv_valid", 64'(slv_q_valid_o), 64'b010);
    chk("loc_slv_id", 64'(slv_q_id_o[1]), 0);
    chk("loc_slv_data", 64'(slv_q_data_o[63:32]), 64'hA5);
    chk("loc_q_ready", 64'(mst_q_ready_o), 64'b01);
    tick();
    idle();
    #1;
    chk("loc_outstanding", 64'(outstanding_o), 1);
    slv_p_valid_i = 3'b010; slv_p_id_i[1] = 1'b1; slv_p_data_i[63:32] = 32'h5A; mst_p_ready_i = 2'b11;
    #1;
    chk("loc_wrong_id_valid", 64'(mst_p_valid_o), 0);
    chk("loc_wrong_id_ready", 64'(slv_p_ready_o), 0);
    slv_p_id_i[1] = 1'b0;
    #1;
    chk("loc_p_valid", 64'(mst_p_valid_o), 64'b01);
    chk("loc_p_data", 64'(mst_p_data_o[31:0]), 64'h5A);
    chk("loc_p_err", 64'(mst_p_err_o[0]), 0);
    chk("loc_slv_p_ready", 64'(slv_p_ready_o), 64'b010);
    tick();
    idle();
    #1;
    chk("loc_drained", 64'(outstanding_o), 0);
    mst_q_valid_i = 2'b01; mst_q_addr_i[5:0] = 6'h02; slv_q_ready_i = 3'b100;
    #1;
    chk("ord_loc_ready", 64'(mst_q_ready_o), 64'b01);
    tick();
    mst_q_addr_i[5:0] = 6'h11; nxt_q_ready_i = 2'b01; slv_q_ready_i = '0;
    #1;
    chk("ord_byp_valid", 64'(nxt_q_valid_o), 64'b01);
    chk("ord_byp_addr", 64'(nxt_q_addr_o[5:0]), 64'h11);
    tick();
    idle();
    nxt_p_valid_i = 2'b01; nxt_p_data_i[31:0] = 32'h77; mst_p_ready_i = 2'b01;
    #1;
    chk("ord_outstanding", 64'(outstanding_o[2:0]), 2);
    for (int c = 0; c < 2; c++) begin
      chk("ord_byp_held_valid", 64'(mst_p_valid_o), 0);
      chk("ord_byp_held_ready", 64'(nxt_p_ready_o), 0);
      tick();
    end
    slv_p_valid_i = 3'b100; slv_p_id_i[2] = 1'b0; slv_p_data_i[95:64] = 32'h22;
    #1;
    chk("ord_first_valid", 64'(mst_p_valid_o), 64'b01);
    chk("ord_first_data", 64'(mst_p_data_o[31:0]), 64'h22);
    chk("ord_first_slv_ready", 64'(slv_p_ready_o), 64'b100);
    chk("ord_first_nxt_ready", 64'(nxt_p_ready_o), 0);
    tick();
    slv_p_valid_i = '0;
    #1;
    chk("ord_second_valid", 64'(mst_p_valid_o), 64'b01);
    chk("ord_second_data", 64'(mst_p_data_o[31:0]), 64'h77);
    chk("ord_second_nxt_ready", 64'(nxt_p_ready_o), 64'b01);
    tick();
    idle();
    #1;
    chk("ord_drained", 64'(outstanding_o), 0);
    mst_q_valid_i = 2'b01; mst_q_addr_i[5:0] = 6'h10; nxt_q_ready_i = 2'b01;
    repeat (4) tick();
    chk("lim_outstanding", 64'(outstanding_o[2:0]), 4);
    chk("lim_full_ready", 64'(mst_q_ready_o), 0);
    chk("lim_full_nxt_valid", 64'(nxt_q_valid_o), 0);
    nxt_p_valid_i = 2'b01; mst_p_ready_i = 2'b01;
    #1;
    chk("lim_no_same_cycle_ready", 64'(mst_q_ready_o), 0);
    chk("lim_pop_valid", 64'(mst_p_valid_o), 64'b01);
    tick();
    nxt_p_valid_i = '0;
    #1;
    chk("lim_after_pop_cnt", 64'(outstanding_o[2:0]), 3);
    chk("lim_after_pop_ready", 64'(mst_q_ready_o), 64'b01);
    tick();
    mst_q_valid_i = '0;
    #1;
    chk("lim_refill_cnt", 64'(outstanding_o[2:0]), 4);
    nxt_p_valid_i = 2'b01; mst_p_ready_i = 2'b01;
    repeat (4) tick();
    idle();
    #1;
    chk("lim_drained", 64'(outstanding_o), 0);
    mst_q_valid_i = 2'b01; mst_q_addr_i[5:0] = 6'h03;
    #1;
    chk("err_ready", 64'(mst_q_ready_o), 64'b01);
    tick();
    idle();
    mst_p_ready_i = 2'b01;
    #1;
    chk("err_p_valid", 64'(mst_p_valid_o), 64'b01);
    chk("err_p_data", 64'(mst_p_data_o[31:0]), 0);
    chk("err_p_err", 64'(mst_p_err_o[0]), 1);
    tick();
    idle();
    #1;
    chk("err_drained", 64'(outstanding_o), 0);
    mst_q_valid_i = 2'b11; mst_q_addr_i = 12'h000; mst_q_data_i = {32'h200, 32'h100}; slv_q_ready_i = 3'b001;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("con%0d_id", c), 64'(slv_q_id_o[0]), 64'(c % 2));
      chk($sformatf("con%0d_ready", c), 64'(mst_q_ready_o), (c % 2) ? 64'b10 : 64'b01);
      chk($sformatf("con%0d_data", c), 64'(slv_q_data_o[31:0]), (c % 2) ? 64'h200 : 64'h100);
      tick();
    end
    idle();
    #1;
    chk("con_outstanding", 64'(outstanding_o), 64'b010_010);
    mst_p_ready_i = 2'b11; slv_p_valid_i = 3'b001;
    for (int c = 0; c < 4; c++) begin
      slv_p_id_i[0] = 1'(c % 2); slv_p_data_i[31:0] = 32'(c + 8);
      #1;
      chk($sformatf("con%0d_p_valid", c), 64'(mst_p_valid_o), (c % 2) ? 64'b10 : 64'b01);
      chk($sformatf("con%0d_p_data", c), (c % 2) ? 64'(mst_p_data_o[63:32]) : 64'(mst_p_data_o[31:0]), 64'(c + 8));
      chk($sformatf("con%0d_slv_ready", c), 64'(slv_p_ready_o), 64'b001);
      tick();
    end
    idle();
    #1;
    chk("con_drained", 64'(outstanding_o), 0);
    mst_q_valid_i = 2'b01; mst_q_addr_i[5:0] = 6'h10; nxt_q_ready_i = 2'b01;
    tick();
    idle();
    #1;
    chk("mid_rst_before", 64'(outstanding_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("mid_rst_cleared", 64'(outstanding_o), 0);
    chk("mid_rst_p_valid", 64'(mst_p_valid_o), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
